// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-packed-BCD converter using the
//                double-dabble algorithm, one input bit per clock, with a
//                start/busy/done handshake. Result held between conversions.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int                 c_BCD_W = 4 * DIGITS;
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic                w_last;

    logic [WIDTH-1:0]    r_sr;
    logic [c_BCD_W-1:0]  r_scr;
    logic                r_ovf_scr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_BCD_W-1:0]  r_bcd;
    logic                r_done;
    logic                r_ovf;

    logic [c_BCD_W-1:0]  w_adj;
    logic [c_BCD_W-1:0]  w_scr_next;
    logic [WIDTH-1:0]    w_sr_next;
    logic                w_ovf_next;

    // Add-3 correction on every digit independently; no carry between digits.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            always_comb begin
                w_adj[4*d +: 4] = (r_scr[4*d +: 4] >= 4'd5) ? (r_scr[4*d +: 4] + 4'd3)
                                                             : r_scr[4*d +: 4];
            end
        end
    endgenerate

    // A one at the scratch MSB after correction would be shifted out: value too large.
    assign w_ovf_next = r_ovf_scr | w_adj[c_BCD_W-1];
    assign w_scr_next = {w_adj[c_BCD_W-2:0], r_sr[WIDTH-1]};
    assign w_sr_next  = {r_sr[WIDTH-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Conversion datapath and registered result; result only moves on the final shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_scr     <= '0;
            r_ovf_scr <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_sr      <= bin;
                r_scr     <= '0;
                r_ovf_scr <= 1'b0;
                r_cnt     <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_sr      <= w_sr_next;
                r_scr     <= w_scr_next;
                r_ovf_scr <= w_ovf_next;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) begin
                    r_bcd  <= w_ovf_next ? {DIGITS{4'h9}} : w_scr_next;
                    r_ovf  <= w_ovf_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bcd      = r_bcd;
    assign done     = r_done;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Directed self-checking bench for bin2bcd_seq, default
//                (16,5) instance plus a (10,3) instance for overflow cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        overflow;

    logic        start_s;
    logic [9:0]  bin_s;
    logic        busy_s;
    logic        done_s;
    logic [11:0] bcd_s;
    logic        overflow_s;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;
    int gap;
    int dcnt;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .bin(bin_s),
        .busy(busy_s), .done(done_s), .bcd(bcd_s), .overflow(overflow_s)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one conversion on the wide instance; returns at the negedge where done is seen.
    task automatic conv(input logic [15:0] v, output int l, output int b);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = ~v;
        l = 0;
        b = 0;
        while (done !== 1'b1 && l < 40) begin
            if (busy === 1'b1) b++;
            @(negedge clk);
            l++;
        end
        if (l >= 40) check("timeout_conv", 32'd0, 32'd1);
    endtask

    task automatic conv_s(input logic [9:0] v, output int l);
        start_s = 1'b1;
        bin_s   = v;
        @(negedge clk);
        start_s = 1'b0;
        l = 0;
        while (done_s !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
        if (l >= 40) check("timeout_conv_s", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        bin     = '0;
        start_s = 1'b0;
        bin_s   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {12'd0, bcd}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zero
        conv(16'd0, lat, bcnt);
        check("t1_lat", lat, 32'd16);
        check("t1_bcd", {12'd0, bcd}, 32'h00000);
        check("t1_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        check("t1_done_1cyc", {31'd0, done}, 32'd0);

        // 2: full scale
        conv(16'd65535, lat, bcnt);
        check("t2_lat", lat, 32'd16);
        check("t2_busy_cycles", bcnt, 32'd16);
        check("t2_bcd", {12'd0, bcd}, 32'h65535);
        check("t2_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        check("t2_busy_after", {31'd0, busy}, 32'd0);

        // 3: start while busy is ignored
        start = 1'b1;
        bin   = 16'd1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 16'd9;
        check("t3_busy_mid", {31'd0, busy}, 32'd1);
        check("t3_bcd_hold", {12'd0, bcd}, 32'h65535);
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t3_lat", lat, 32'd16);
        check("t3_bcd", {12'd0, bcd}, 32'h01234);
        @(negedge clk);
        check("t3_no_queue", {31'd0, busy}, 32'd0);
        conv(16'd9, lat, bcnt);
        check("t3_bcd9", {12'd0, bcd}, 32'h00009);

        // 4: narrow instance, overflow boundary
        conv_s(10'd999, lat);
        check("t4_lat", lat, 32'd10);
        check("t4_999_bcd", {20'd0, bcd_s}, 32'h999);
        check("t4_999_ovf", {31'd0, overflow_s}, 32'd0);
        conv_s(10'd1000, lat);
        check("t4_1000_bcd", {20'd0, bcd_s}, 32'h999);
        check("t4_1000_ovf", {31'd0, overflow_s}, 32'd1);
        conv_s(10'd1023, lat);
        check("t4_1023_bcd", {20'd0, bcd_s}, 32'h999);
        check("t4_1023_ovf", {31'd0, overflow_s}, 32'd1);
        conv_s(10'd5, lat);
        check("t4_5_bcd", {20'd0, bcd_s}, 32'h005);
        check("t4_5_ovf", {31'd0, overflow_s}, 32'd0);

        // 5: start held high, back-to-back
        start = 1'b1;
        bin   = 16'd7;
        @(negedge clk);
        bin = 16'd42;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t5_lat", lat, 32'd16);
        check("t5_bcd7", {12'd0, bcd}, 32'h00007);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done !== 1'b1 && gap < 40);
        start = 1'b0;
        check("t5_gap", gap, 32'd17);
        check("t5_bcd42", {12'd0, bcd}, 32'h00042);

        // 6: reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_bcd", {12'd0, bcd}, 32'h00000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("t6_no_done", dcnt, 32'd0);
        conv(16'd500, lat, bcnt);
        check("t6_lat", lat, 32'd16);
        check("t6_bcd500", {12'd0, bcd}, 32'h00500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
